// File: rtl/led_share_sched_if.sv
// Status/LED handshake between requesters and the LED time-share scheduler.
// Requesters drive req/pattern/duty; the scheduler drives grant/busy/leds.
`timescale 1ns/1ps
interface led_share_sched_if #(
  parameter int N_REQ = 4,
  parameter int PWM_W = 4
);
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] pattern;
  logic [PWM_W-1:0]   duty;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [2:0]         leds;

  modport master (output req, pattern, duty, input grant, busy, leds);
  modport slave  (input req, pattern, duty, output grant, busy, leds);
endinterface

// File: rtl/led_share_sched.sv
// Round-robin time-sharing of a 3-bit LED bank: SHOW dwell per grant, dark GAP,
// heartbeat counter when idle, all outputs brightness-limited by a global PWM duty.
`timescale 1ns/1ps
module led_share_sched #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 8388608,
  parameter int GAP_CYCLES  = 1048576,
  parameter int IDLE_CTR_W  = 26,
  parameter int PWM_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  led_share_sched_if.slave   bus
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES - 1 : GAP_CYCLES - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [2:0]             leds_q, leds_d;
  logic [2:0]             shown_q, shown_d;
  logic [IDLE_CTR_W-1:0]  ctr_q, ctr_d;
  logic [PWM_W-1:0]       pwm_ctr_q, pwm_ctr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [PTR_W-1:0]       winner;
  logic                   any_req;
  logic                   start_grant;
  logic                   pwm_on;
  logic [2:0]             display;

  // Search starts just after the last winner, so a steady requester waits at most N_REQ-1 grants.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any_req && bus.req[(int'(rr_ptr_q) + k) % N_REQ]) begin
        any_req = 1'b1;
        winner  = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    shown_d     = shown_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    ctr_d       = ctr_q + 1'b1;
    pwm_ctr_d   = pwm_ctr_q + 1'b1;
    start_grant = 1'b0;

    case (state_q)
      IDLE: start_grant = any_req;
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          grant_d = '0;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (any_req) begin
          start_grant = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Pattern is captured only here; later changes by the requester are ignored until the next grant.
    if (start_grant) begin
      state_d  = SHOW;
      grant_d  = N_REQ'(1) << winner;
      rr_ptr_d = winner;
      shown_d  = bus.pattern[3*int'(winner) +: 3];
      cnt_d    = CNT_W'(HOLD_CYCLES - 1);
      busy_d   = 1'b1;
    end

    // Display follows the state being entered so leds change on the same edge as grant.
    case (state_d)
      SHOW:    display = shown_d;
      GAP:     display = 3'b000;
      default: display = ctr_q[IDLE_CTR_W-1 -: 3];
    endcase

    pwm_on = (pwm_ctr_q < bus.duty);
    leds_d = display & {3{pwm_on}};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      leds_q    <= 3'b000;
      shown_q   <= 3'b000;
      ctr_q     <= '0;
      pwm_ctr_q <= '0;
      cnt_q     <= '0;
      rr_ptr_q  <= PTR_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      leds_q    <= leds_d;
      shown_q   <= shown_d;
      ctr_q     <= ctr_d;
      pwm_ctr_q <= pwm_ctr_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.leds  = leds_q;

endmodule

// File: doc/led_share_sched.md
Name: led_share_sched

Overview:
- Time-shares the 3-bit board LED bank of the GW1N1 generic-IOB blinky design between up to N_REQ status requesters.
- Round-robin arbitration; each grant holds the LEDs for a fixed dwell, followed by a dark gap.
- When no requester is active, the LEDs show the top bits of a free-running heartbeat counter.
- All LED outputs are brightness-limited by a global PWM duty. The block sits between internal status logic and the LED output IOBs.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- HOLD_CYCLES, 8388608: SHOW dwell per grant, in clk cycles, >=1.
- GAP_CYCLES, 1048576: dark cycles between consecutive grants, >=1.
- IDLE_CTR_W, 26: width of the heartbeat counter. Idle display is ctr[IDLE_CTR_W-1 -: 3].
- PWM_W, 4: width of the PWM counter and of duty.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- pattern  input  3*N_REQ  LED pattern; requester i uses bits [3i+2:3i].
- duty  input  PWM_W  global brightness.
- grant  output  N_REQ  one-hot, marks the requester currently shown.
- busy  output  1  high in SHOW or GAP.
- leds  output  3  LED drive, active-high, registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, busy=0, leds=0, heartbeat ctr=0, pwm_ctr=0, hold/gap counter=0, rr_ptr=N_REQ-1. With this rr_ptr, requester 0 wins the first arbitration after reset.
- Heartbeat ctr: IDLE_CTR_W bits, increments every cycle in all states, wraps to 0 after all-ones.
- pwm_ctr: PWM_W bits, increments every cycle, wraps. pwm_on = (pwm_ctr < duty).
  - duty=0 gives permanently dark LEDs.
  - Maximum on-fraction is (2^PWM_W-1)/2^PWM_W.
- Arbitration (combinational, same rule in every state): winner = first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
- State machine, all transitions on the clk edge:
  - IDLE, no req: stay in IDLE. Display = heartbeat top 3 bits.
  - IDLE, any req: go to SHOW.
    - grant <= onehot(winner), rr_ptr <= winner.
    - shown <= pattern slice of winner, latched once at grant time.
    - cnt <= HOLD_CYCLES-1, busy <= 1.
  - SHOW: display = shown.
    - cnt != 0: decrement.
    - cnt == 0: go to GAP. cnt <= GAP_CYCLES-1, grant <= 0, display = 000.
  - GAP: display = 000.
    - cnt != 0: decrement.
    - cnt == 0 and any req: go to SHOW, same actions as the IDLE->SHOW transition.
    - cnt == 0 and no req: go to IDLE, busy <= 0.
- Output: leds <= display & {3{pwm_on}}. The pwm_on term uses the pre-increment pwm_ctr of the same cycle.
- Latency: req sampled high at edge t from IDLE gives grant and busy valid after edge t. leds reflect the pattern from that edge onward, subject to PWM.
- A SHOW lasts exactly HOLD_CYCLES cycles. A GAP lasts exactly GAP_CYCLES cycles.
- Requester deasserts req or changes pattern during SHOW: no effect. The grant runs to completion with the latched pattern.
- Simultaneous requests: strict round robin. A requester that is continuously requesting is granted at least once every N_REQ grants.
- Single persistent requester: re-granted after every GAP. No IDLE cycle is inserted between its grants.
- rst asserted mid-SHOW or mid-GAP: all outputs go to reset values immediately, without waiting for a clk edge.

Test Plan:
Bench parameters: N_REQ=4, HOLD_CYCLES=4, GAP_CYCLES=2, IDLE_CTR_W=6, PWM_W=2, duty=3 unless stated.
- Reset check: hold rst, no req, run 64 cycles after release.
  - grant=0, busy=0.
  - Ungated display steps through 000..111, changing every 8 cycles.
- Single grant: pulse req[2] for 1 cycle with pattern[8:6]=101.
  - grant=0100 for exactly 4 cycles, then 2 cycles at display 000, then IDLE with busy=0.
  - Gated leds=101 only on cycles where pwm_ctr<3.
- Round robin: req=1111 held constant.
  - Grant sequence is 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 4 cycles; grants are separated by 2-cycle gaps.
- Latch check: change pattern[2:0] from 011 to 110 mid-SHOW of requester 0.
  - leds stay 011 (gated) until SHOW ends.
- PWM limits:
  - duty=0: leds=000 always.
  - duty=1: each lit LED is on 1 cycle in every 4.
- Async reset mid-SHOW: assert rst between edges.
  - grant, busy and leds go to 0 within the same cycle.
  - After release, req=1111 grants requester 0 first.
